qrisc32_hazard_ctrl: RTL and testbench
======================================

QRISC32_HAZARD_CTRL -- requirements
Module: qrisc32_hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of wrong-path cycles squashed after a taken jump (legal 1..15).
REQ-002 Parameter CNT_W, default 16, width of the performance counters.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 id_valid  input  1  ID stage holds a real instruction (instruction word != 0).
REQ-006 id_src_r1, id_src_r2, id_dst_r  input  5 each  register fields of the instruction in ID.
REQ-007 id_use_r1, id_use_r2, id_use_dst  input  1 each  ID instruction reads that field (id_use_dst for STR and RET).
REQ-008 ex_read_mem  input  1  instruction now in EX is a memory load (LDRP).
REQ-009 ex_dst_r  input  5  destination register of the EX instruction.
REQ-010 ex_jump_taken  input  1  EX resolved a taken jump, call or return this cycle.
REQ-011 mem_busy  input  1  MEM stage cannot accept a new access this cycle.
REQ-012 stall_if  output  1  hold PC and fetch register.
REQ-013 stall_id  output  1  hold ID output register (drives ID pipe_stall).
REQ-014 stall_ex  output  1  hold EX output register.
REQ-015 bubble_ex  output  1  load all-zero (NOP) pipe_struct into EX.
REQ-016 flush_if_id  output  1  replace IF and ID contents with NOP.
REQ-017 state  output  2  FSM state: RUN=0, FLUSH=2, MEM_WAIT=3 (1 unused).
REQ-018 stall_count, flush_count  output  CNT_W each  performance counters.

Function
REQ-019 Load-use hazard (luh) SHALL be id_valid & ex_read_mem & ((id_use_r1 & id_src_r1==ex_dst_r) | (id_use_r2 & id_src_r2==ex_dst_r) | (id_use_dst & id_dst_r==ex_dst_r)); R0 is a normal register, no exemption.
REQ-020 Event priority SHALL be mem_busy > ex_jump_taken > luh; lower events are ignored in a cycle where a higher one is active.
REQ-021 mem_busy=1 (any state) SHALL assert stall_if, stall_id, stall_ex combinationally that cycle, bubble_ex=0, flush_if_id=0; next state MEM_WAIT.
REQ-022 MEM_WAIT with mem_busy=0 SHALL deassert all stalls that cycle and return to RUN next cycle; a pending flush count SHALL be preserved across MEM_WAIT and resumed as FLUSH.
REQ-023 ex_jump_taken (mem_busy=0) SHALL assert flush_if_id combinationally that cycle and load flush counter with FLUSH_CYCLES-1; next state FLUSH if counter>0, else RUN.
REQ-024 FLUSH SHALL assert flush_if_id each cycle, decrement the counter, and return to RUN in the cycle after counter reaches 0; ex_jump_taken in FLUSH reloads the counter.
REQ-025 luh in RUN (no higher event) SHALL assert stall_if, stall_id, bubble_ex for exactly one cycle, stall_ex=0; no state change; luh SHALL be ignored in FLUSH.
REQ-026 With no event in RUN all control outputs SHALL be 0.
REQ-027 stall_count SHALL increment on every cycle stall_id=1; flush_count SHALL increment once per accepted ex_jump_taken; both saturate at all-ones.

Reset
REQ-028 reset SHALL force state=RUN, flush counter=0, stall_count=0, flush_count=0 on the next edge, abandoning any FLUSH or MEM_WAIT in progress.
REQ-029 While reset=1 all control outputs SHALL be 0 regardless of inputs.

Verification
REQ-030 ex_read_mem=1, ex_dst_r=5, id_src_r1=5, id_use_r1=1, id_valid=1 -> one cycle stall_if=stall_id=bubble_ex=1, stall_count=1.
REQ-031 ex_jump_taken pulse, FLUSH_CYCLES=2 -> flush_if_id=1 for 2 cycles, state RUN->FLUSH->RUN, flush_count=1.
REQ-032 mem_busy high 3 cycles with simultaneous ex_jump_taken and luh -> stall_if/id/ex=1 for 3 cycles, no flush, no bubble, flush_count unchanged.
REQ-033 mem_busy during FLUSH with 1 flush cycle left -> MEM_WAIT, then 1 flush cycle after release, then RUN.
REQ-034 reset asserted mid-FLUSH with stall_count=7 -> outputs 0 during reset, state=RUN, counters 0 after.
REQ-035 Counter saturation: CNT_W=4, 20 consecutive luh stalls -> stall_count holds 15.

Source files
------------

// File: rtl/qrisc32_hazard_ctrl.sv
// Pipeline hazard controller for the qrisc32 core: resolves memory back-pressure,
// taken-jump wrong-path squashing and load-use interlocks, with stall/flush counters.
module qrisc32_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_src_r1,
  input  logic [4:0]       id_src_r2,
  input  logic [4:0]       id_dst_r,
  input  logic             id_use_r1,
  input  logic             id_use_r2,
  input  logic             id_use_dst,
  input  logic             ex_read_mem,
  input  logic [4:0]       ex_dst_r,
  input  logic             ex_jump_taken,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned FC_W = 4;
  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_UNUSED   = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  state_t          cur_state;
  state_t          nxt_state;
  logic [FC_W-1:0] flush_cnt;
  logic [FC_W-1:0] flush_cnt_nxt;
  logic            luh;
  logic            jump_accept;

  // Load in EX produces a register the ID instruction consumes; R0 is not exempt.
  always_comb begin
    luh = id_valid & ex_read_mem &
          ((id_use_r1  & (id_src_r1 == ex_dst_r)) |
           (id_use_r2  & (id_src_r2 == ex_dst_r)) |
           (id_use_dst & (id_dst_r  == ex_dst_r)));
  end

  assign jump_accept = ex_jump_taken & ~mem_busy & ~reset;

  // State and wrong-path counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next-state: memory back-pressure freezes the flush count so it resumes afterwards
  always_comb begin
    nxt_state     = cur_state;
    flush_cnt_nxt = flush_cnt;
    if (mem_busy) begin
      nxt_state = ST_MEM_WAIT;
    end else if (ex_jump_taken) begin
      flush_cnt_nxt = FLUSH_RELOAD;
      nxt_state     = (FLUSH_RELOAD != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      unique case (cur_state)
        ST_MEM_WAIT: nxt_state = (flush_cnt != '0) ? ST_FLUSH : ST_RUN;
        ST_FLUSH: begin
          if (flush_cnt != '0) begin
            flush_cnt_nxt = flush_cnt - FC_W'(1);
          end
          nxt_state = (flush_cnt > FC_W'(1)) ? ST_FLUSH : ST_RUN;
        end
        ST_RUN:    nxt_state = ST_RUN;
        default:   nxt_state = ST_RUN;
      endcase
    end
  end

  // Control outputs respond in the same cycle as the event that causes them
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
      end else if (ex_jump_taken) begin
        flush_if_id = 1'b1;
      end else begin
        unique case (cur_state)
          ST_FLUSH: flush_if_id = 1'b1;
          ST_RUN: begin
            if (luh) begin
              stall_if  = 1'b1;
              stall_id  = 1'b1;
              bubble_ex = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_id && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (jump_accept && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_qrisc32_hazard_ctrl.sv
// Scoreboard bench for qrisc32_hazard_ctrl: two instances (default and narrow counters)
// share stimulus and are checked every cycle against an event-level reference model.
module tb_qrisc32_hazard_ctrl;

  localparam int FC_A = 2;
  localparam int FC_B = 3;
  localparam int CW_B = 4;

  logic       clk = 1'b0;
  logic       reset, id_valid, id_use_r1, id_use_r2, id_use_dst;
  logic       ex_read_mem, ex_jump_taken, mem_busy;
  logic [4:0] id_src_r1, id_src_r2, id_dst_r, ex_dst_r;

  logic        sif_a, sid_a, sex_a, bub_a, fl_a;
  logic [1:0]  st_a;
  logic [15:0] sc_a, fc_a;
  logic        sif_b, sid_b, sex_b, bub_b, fl_b;
  logic [1:0]  st_b;
  logic [CW_B-1:0] sc_b, fc_b;

  always #5 clk = ~clk;

  qrisc32_hazard_ctrl #(.FLUSH_CYCLES(FC_A), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_src_r1(id_src_r1), .id_src_r2(id_src_r2), .id_dst_r(id_dst_r),
    .id_use_r1(id_use_r1), .id_use_r2(id_use_r2), .id_use_dst(id_use_dst),
    .ex_read_mem(ex_read_mem), .ex_dst_r(ex_dst_r), .ex_jump_taken(ex_jump_taken),
    .mem_busy(mem_busy), .stall_if(sif_a), .stall_id(sid_a), .stall_ex(sex_a),
    .bubble_ex(bub_a), .flush_if_id(fl_a), .state(st_a),
    .stall_count(sc_a), .flush_count(fc_a));

  qrisc32_hazard_ctrl #(.FLUSH_CYCLES(FC_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_src_r1(id_src_r1), .id_src_r2(id_src_r2), .id_dst_r(id_dst_r),
    .id_use_r1(id_use_r1), .id_use_r2(id_use_r2), .id_use_dst(id_use_dst),
    .ex_read_mem(ex_read_mem), .ex_dst_r(ex_dst_r), .ex_jump_taken(ex_jump_taken),
    .mem_busy(mem_busy), .stall_if(sif_b), .stall_id(sid_b), .stall_ex(sex_b),
    .bubble_ex(bub_b), .flush_if_id(fl_b), .state(st_b),
    .stall_count(sc_b), .flush_count(fc_b));

  typedef struct {
    bit rst, v, u1, u2, ud, rm, jt, mb;
    logic [4:0] r1, r2, rd, exd;
  } stim_t;

  // Model view: flush cycles still owed, whether MEM is holding us, and event tallies
  typedef struct {
    int owed;
    bit waiting;
    int stalls;
    int flushes;
  } mstate_t;

  // ctl = {stall_if, stall_id, stall_ex, bubble_ex, flush_if_id}
  typedef struct {
    int ctl;
    int st;
    int sc;
    int fc;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } pair_t;

  pair_t   sb_q[$];
  mstate_t ms_a, ms_b;
  int      n_checks = 0;
  int      n_pass   = 0;

  function automatic bit is_luh(input stim_t s);
    return s.v && s.rm && ((s.u1 && s.r1 == s.exd) || (s.u2 && s.r2 == s.exd) ||
                           (s.ud && s.rd == s.exd));
  endfunction

  function automatic void model_step(input mstate_t si, input int fcyc, input int cmax,
                                     input stim_t s, output exp_t e, output mstate_t so);
    so    = si;
    e.st  = si.waiting ? 3 : ((si.owed > 0) ? 2 : 0);
    e.sc  = si.stalls;
    e.fc  = si.flushes;
    e.ctl = 0;
    if (s.rst) begin
      so = '{0, 1'b0, 0, 0};
    end else if (s.mb) begin
      e.ctl = 5'b11100;
      so.waiting = 1'b1;
      if (so.stalls < cmax) so.stalls++;
    end else if (s.jt) begin
      e.ctl = 5'b00001;
      so.waiting = 1'b0;
      so.owed = fcyc - 1;
      if (so.flushes < cmax) so.flushes++;
    end else if (si.waiting) begin
      so.waiting = 1'b0;
    end else if (si.owed > 0) begin
      e.ctl = 5'b00001;
      so.owed--;
    end else if (is_luh(s)) begin
      e.ctl = 5'b11010;
      if (so.stalls < cmax) so.stalls++;
    end
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input stim_t s, input bit chk);
    pair_t p;
    mstate_t na, nb;
    @(negedge clk);
    reset = s.rst; id_valid = s.v; id_use_r1 = s.u1; id_use_r2 = s.u2; id_use_dst = s.ud;
    ex_read_mem = s.rm; ex_jump_taken = s.jt; mem_busy = s.mb;
    id_src_r1 = s.r1; id_src_r2 = s.r2; id_dst_r = s.rd; ex_dst_r = s.exd;
    model_step(ms_a, FC_A, 65535, s, p.a, na);
    model_step(ms_b, FC_B, (1 << CW_B) - 1, s, p.b, nb);
    ms_a = na;
    ms_b = nb;
    if (chk) sb_q.push_back(p);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0};
    return s;
  endfunction

  function automatic stim_t luh_stim();
    stim_t s;
    s = idle();
    s.v = 1'b1; s.rm = 1'b1; s.exd = 5'd5; s.r1 = 5'd5; s.u1 = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim(input int rst_pct);
    stim_t s;
    s.rst = ($urandom_range(0, 99) < rst_pct);
    s.mb  = ($urandom_range(0, 99) < 12);
    s.jt  = ($urandom_range(0, 99) < 12);
    s.v   = ($urandom_range(0, 99) < 85);
    s.rm  = ($urandom_range(0, 99) < 50);
    s.u1  = 1'($urandom);
    s.u2  = 1'($urandom);
    s.ud  = 1'($urandom);
    s.r1  = 5'($urandom_range(0, 3));
    s.r2  = 5'($urandom_range(0, 3));
    s.rd  = 5'($urandom_range(0, 3));
    s.exd = 5'($urandom_range(0, 3));
    return s;
  endfunction

  // Monitor: outputs are valid every cycle, sampled mid-low-phase after the drive settles
  pair_t mp;
  always @(negedge clk) begin
    #2;
    if (sb_q.size() > 0) begin
      mp = sb_q.pop_front();
      check("a_ctl",   int'({sif_a, sid_a, sex_a, bub_a, fl_a}), mp.a.ctl);
      check("a_state", int'(st_a), mp.a.st);
      check("a_stall_count", int'(sc_a), mp.a.sc);
      check("a_flush_count", int'(fc_a), mp.a.fc);
      check("b_ctl",   int'({sif_b, sid_b, sex_b, bub_b, fl_b}), mp.b.ctl);
      check("b_state", int'(st_b), mp.b.st);
      check("b_stall_count", int'(sc_b), mp.b.sc);
      check("b_flush_count", int'(fc_b), mp.b.fc);
    end
  end

  initial begin
    stim_t s;
    ms_a = '{0, 1'b0, 0, 0};
    ms_b = '{0, 1'b0, 0, 0};
    s = idle();
    s.rst = 1'b1;
    drive(s, 1'b0);
    // Reset with busy inputs must still hold every control output low
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(0);
      s.rst = 1'b1; s.mb = 1'b1; s.jt = 1'b1;
      drive(s, 1'b1);
    end
    // Single load-use stall
    drive(luh_stim(), 1'b1);
    drive(idle(), 1'b1);
    // Taken-jump pulse and wrong-path squash
    s = idle(); s.jt = 1'b1;
    drive(s, 1'b1);
    for (int i = 0; i < 4; i++) drive(idle(), 1'b1);
    // MEM busy masks simultaneous jump and load-use
    s = luh_stim(); s.jt = 1'b1; s.mb = 1'b1;
    for (int i = 0; i < 3; i++) drive(s, 1'b1);
    for (int i = 0; i < 4; i++) drive(idle(), 1'b1);
    // MEM busy arriving mid-flush, then resumption
    s = idle(); s.jt = 1'b1;
    drive(s, 1'b1);
    s = idle(); s.mb = 1'b1;
    drive(s, 1'b1);
    drive(s, 1'b1);
    for (int i = 0; i < 5; i++) drive(idle(), 1'b1);
    // Reset abandons a flush after seven stalls
    s = idle(); s.rst = 1'b1;
    drive(s, 1'b1);
    for (int i = 0; i < 7; i++) drive(luh_stim(), 1'b1);
    s = idle(); s.jt = 1'b1;
    drive(s, 1'b1);
    s = luh_stim(); s.rst = 1'b1; s.mb = 1'b1;
    drive(s, 1'b1);
    drive(s, 1'b1);
    for (int i = 0; i < 3; i++) drive(idle(), 1'b1);
    // Twenty consecutive load-use stalls saturate the narrow counter
    for (int i = 0; i < 20; i++) drive(luh_stim(), 1'b1);
    drive(idle(), 1'b1);
    // Randomized traffic
    for (int i = 0; i < 600; i++) drive(rand_stim(2), 1'b1);
    for (int i = 0; i < 3; i++) drive(idle(), 1'b1);
    @(negedge clk);
    #5;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
